// File: rtl/dpll_dco_if.sv
// dpll_dco_if: early/late pulses into the bit-sync DCO, recovered clocks and loop status out.
interface dpll_dco_if;
    logic pd_bef_i;
    logic pd_aft_i;
    logic clk_i_o;
    logic clk_q_o;
    logic sample_stb_o;
    logic lock_o;
    logic corr_add_o;
    logic corr_ded_o;
    modport master (
        output pd_bef_i, pd_aft_i,
        input  clk_i_o, clk_q_o, sample_stb_o, lock_o, corr_add_o, corr_ded_o
    );
    modport slave (
        input  pd_bef_i, pd_aft_i,
        output clk_i_o, clk_q_o, sample_stb_o, lock_o, corr_add_o, corr_ded_o
    );
endinterface

// File: rtl/dpll_dco.sv
// dpll_dco: random-walk filtered add/deduct controller driving a divide-by-DIV phase counter
// that produces I/Q bit clocks, a mid-bit sample strobe and a lock flag.
module dpll_dco #(
    parameter int DIV      = 32,
    parameter int FILT_N   = 2,
    parameter int LOCK_CNT = 8
) (
    input logic       clk32_i,
    input logic       rst_n_i,
    dpll_dco_if.slave bus
);
    localparam int W = $clog2(DIV);
    localparam logic [W:0]          DIV_W = (W+1)'(DIV);
    localparam logic [W-1:0]        HALF  = W'(DIV / 2);
    localparam logic [W-1:0]        Q_LO  = W'(DIV / 4);
    localparam logic [W-1:0]        Q_HI  = W'(3 * DIV / 4);
    localparam logic signed [4:0]   FN    = 5'(FILT_N);
    localparam logic [7:0]          LC    = 8'(LOCK_CNT);

    logic [W-1:0]      cnt;
    logic [W-1:0]      cnt_nxt;
    logic [W:0]        sum;
    logic [1:0]        step;
    logic signed [4:0] filt;
    logic signed [4:0] filt_nxt;
    logic              used;
    logic [7:0]        lock_cnt;
    logic              dir_up;
    logic              dir_dn;
    logic              grant_add;
    logic              grant_ded;
    logic              grant;
    logic              wrap;

    always_comb begin
        dir_up    = bus.pd_bef_i & ~bus.pd_aft_i;
        dir_dn    = bus.pd_aft_i & ~bus.pd_bef_i;
        grant_add = ~used & (filt == -FN);
        grant_ded = ~used & (filt == FN);
        grant     = grant_add | grant_ded;
        step      = grant_add ? 2'd2 : grant_ded ? 2'd0 : 2'd1;
        sum       = {1'b0, cnt} + {{(W-1){1'b0}}, step};
        cnt_nxt   = (sum >= DIV_W) ? W'(sum - DIV_W) : sum[W-1:0];
        // a deduct holds the counter, so it can never be mistaken for a wrap
        wrap      = (step != 2'd0) && (cnt_nxt <= cnt);
        filt_nxt  = grant ? 5'sd0 : filt;
        filt_nxt  = (dir_up && filt_nxt < FN)  ? filt_nxt + 5'sd1 :
                    (dir_dn && filt_nxt > -FN) ? filt_nxt - 5'sd1 : filt_nxt;
    end

    always_ff @(posedge clk32_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt              <= '0;
            filt             <= '0;
            used             <= 1'b0;
            lock_cnt         <= '0;
            bus.clk_i_o      <= 1'b0;
            bus.clk_q_o      <= 1'b0;
            bus.sample_stb_o <= 1'b0;
            bus.lock_o       <= 1'b0;
            bus.corr_add_o   <= 1'b0;
            bus.corr_ded_o   <= 1'b0;
        end else begin
            cnt              <= cnt_nxt;
            filt             <= filt_nxt;
            // a wrap re-arms the per-period correction slot, even on the grant cycle itself
            used             <= wrap ? 1'b0 : grant ? 1'b1 : used;
            lock_cnt         <= grant ? 8'd0 :
                                (wrap && !used && lock_cnt != LC) ? lock_cnt + 8'd1 : lock_cnt;
            bus.clk_i_o      <= cnt < HALF;
            bus.clk_q_o      <= (cnt >= Q_LO) && (cnt < Q_HI);
            bus.sample_stb_o <= cnt == HALF;
            bus.lock_o       <= lock_cnt == LC;
            bus.corr_add_o   <= grant_add;
            bus.corr_ded_o   <= grant_ded;
        end
    end
endmodule

// File: tb/tb_dpll_dco.sv
// tb_dpll_dco: two DCO instances (FILT_N=2 and FILT_N=1) checked with a period scoreboard,
// a table of pulse patterns and hand-written reset / lock sequences.
module tb_dpll_dco;
    logic clk32 = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   sel = 2;
    int   exp_q[$];
    int   n_add[1:2];
    int   n_ded[1:2];
    int   last_rise = 0;
    bit   have_last = 1'b0;
    logic prev_ci = 1'b0;

    typedef struct {
        int   s;
        int   c0;
        int   l0;
        logic b0;
        logic a0;
        int   c1;
        int   l1;
        logic b1;
        logic a1;
        int   e_add;
        int   e_ded;
        int   p0;
        int   p1;
    } vec_t;
    vec_t tbl[7];

    dpll_dco_if if1();
    dpll_dco_if if2();

    dpll_dco #(.DIV(32), .FILT_N(2), .LOCK_CNT(8)) u_dut2 (
        .clk32_i (clk32),
        .rst_n_i (rst_n),
        .bus     (if2.slave)
    );
    dpll_dco #(.DIV(32), .FILT_N(1), .LOCK_CNT(8)) u_dut1 (
        .clk32_i (clk32),
        .rst_n_i (rst_n),
        .bus     (if1.slave)
    );

    always #5 clk32 = ~clk32;
    always @(posedge clk32) cyc <= cyc + 1;

    function automatic logic [5:0] outs(input int s);
        return (s == 1) ?
            {if1.clk_i_o, if1.clk_q_o, if1.sample_stb_o, if1.lock_o, if1.corr_add_o, if1.corr_ded_o} :
            {if2.clk_i_o, if2.clk_q_o, if2.sample_stb_o, if2.lock_o, if2.corr_add_o, if2.corr_ded_o};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input int s, input logic b, input logic a);
        if (s == 1) begin
            if1.pd_bef_i = b;
            if1.pd_aft_i = a;
        end else begin
            if2.pd_bef_i = b;
            if2.pd_aft_i = a;
        end
    endtask

    // monitor: counts correction pulses and scores clk_i_o rise-to-rise periods
    always @(posedge clk32) begin
        logic [5:0] o;
        #1;
        n_add[1] += int'(if1.corr_add_o);
        n_ded[1] += int'(if1.corr_ded_o);
        n_add[2] += int'(if2.corr_add_o);
        n_ded[2] += int'(if2.corr_ded_o);
        if (!rst_n) begin
            have_last = 1'b0;
            prev_ci   = 1'b0;
        end else begin
            o = outs(sel);
            if (o[5] && !prev_ci) begin
                if (have_last && exp_q.size() > 0) chk("period", cyc - last_rise, exp_q.pop_front());
                last_rise = cyc;
                have_last = 1'b1;
            end
            prev_ci = o[5];
        end
    end

    task automatic wait_level(input int s, input int bitn, input logic lvl, input int budget, output int ok);
        logic [5:0] o;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk32);
            o = outs(s);
            if (o[bitn] == lvl) begin
                ok = 1;
                break;
            end
        end
    endtask

    // returns at the negedge just after clk_i_o rose, i.e. while the phase counter holds 1
    task automatic sync_rise(input int s);
        int ok_lo;
        int ok_hi;
        sel = s;
        wait_level(s, 5, 1'b0, 40, ok_lo);
        wait_level(s, 5, 1'b1, 40, ok_hi);
        chk("sync_rise", ok_lo & ok_hi, 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 400) begin
            @(negedge clk32);
            n++;
        end
        chk("drain", exp_q.size(), 0);
        exp_q.delete();
        repeat (2) @(negedge clk32);
    endtask

    task automatic post_reset_checks(input int s);
        logic [5:0] o;
        for (int k = 1; k <= 257; k++) begin
            @(negedge clk32);
            o = outs(s);
            if (k == 8) begin
                chk("clk_i_high_k8", int'(o[5]), 1);
                chk("clk_q_low_k8", int'(o[4]), 0);
            end
            if (k == 9)  chk("clk_q_rise_k9", int'(o[4]), 1);
            if (k == 16) begin
                chk("clk_i_high_k16", int'(o[5]), 1);
                chk("stb_low_k16", int'(o[3]), 0);
            end
            if (k == 17) begin
                chk("clk_i_fall_k17", int'(o[5]), 0);
                chk("stb_k17", int'(o[3]), 1);
            end
            if (k == 18)  chk("stb_one_cycle", int'(o[3]), 0);
            if (k == 256) chk("lock_before_8th", int'(o[2]), 0);
            if (k == 257) chk("lock_after_8th", int'(o[2]), 1);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish, expected finish before timeout");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ok;
        int na;
        int nd;
        int t_ded;
        n_add = '{0, 0};
        n_ded = '{0, 0};
        tbl[0] = '{2,  5,  1, 1'b0, 1'b1,  8, 1, 1'b0, 1'b1, 1, 0, 31, 32};
        tbl[1] = '{2,  5,  1, 1'b0, 1'b1, 10, 1, 1'b1, 1'b0, 0, 0, 32, 32};
        tbl[2] = '{2,  5, 10, 1'b1, 1'b1,  0, 0, 1'b0, 1'b0, 0, 0, 32, 32};
        tbl[3] = '{1, 29,  2, 1'b0, 1'b1,  0, 0, 1'b0, 1'b0, 2, 0, 31, 31};
        tbl[4] = '{1, 30,  1, 1'b0, 1'b1,  0, 0, 1'b0, 1'b0, 1, 0, 32, 31};
        tbl[5] = '{1,  5,  1, 1'b1, 1'b0,  0, 0, 1'b0, 1'b0, 0, 1, 33, 32};
        tbl[6] = '{1, 30,  2, 1'b1, 1'b0,  0, 0, 1'b0, 1'b0, 0, 2, 33, 33};
        drive(1, 1'b0, 1'b0);
        drive(2, 1'b0, 1'b0);
        sel = 2;
        rst_n = 1'b0;
        repeat (3) @(negedge clk32);
        chk("reset_outs_u2", int'(outs(2)), 0);
        chk("reset_outs_u1", int'(outs(1)), 0);
        rst_n = 1'b1;
        repeat (4) exp_q.push_back(32);
        post_reset_checks(2);
        drain();

        // FILT_N=1: single early pulse at cnt=5, lock drops then returns 283 cycles later
        chk("u1_locked_pre", int'(if1.lock_o), 1);
        sync_rise(1);
        exp_q.push_back(33);
        exp_q.push_back(32);
        nd = n_ded[1];
        repeat (4) @(negedge clk32);
        drive(1, 1'b1, 1'b0);
        @(negedge clk32);
        drive(1, 1'b0, 1'b0);
        wait_level(1, 0, 1'b1, 10, ok);
        chk("ded_seen", ok, 1);
        t_ded = cyc;
        @(negedge clk32);
        chk("lock_drop", int'(if1.lock_o), 0);
        wait_level(1, 2, 1'b1, 400, ok);
        chk("relock_seen", ok, 1);
        chk("relock_cycles", cyc - t_ded, 283);
        drain();
        chk("single_ded_count", n_ded[1] - nd, 1);

        for (int i = 0; i < 7; i++) begin
            int s;
            s = tbl[i].s;
            sync_rise(s);
            exp_q.push_back(tbl[i].p0);
            exp_q.push_back(tbl[i].p1);
            na = n_add[s];
            nd = n_ded[s];
            repeat (tbl[i].c0 - 1) @(negedge clk32);
            drive(s, tbl[i].b0, tbl[i].a0);
            repeat (tbl[i].l0) @(negedge clk32);
            drive(s, 1'b0, 1'b0);
            if (tbl[i].l1 > 0) begin
                repeat (tbl[i].c1 - tbl[i].c0 - tbl[i].l0) @(negedge clk32);
                drive(s, tbl[i].b1, tbl[i].a1);
                repeat (tbl[i].l1) @(negedge clk32);
                drive(s, 1'b0, 1'b0);
            end
            drain();
            chk($sformatf("vec%0d_adds", i), n_add[s] - na, tbl[i].e_add);
            chk($sformatf("vec%0d_deds", i), n_ded[s] - nd, tbl[i].e_ded);
        end

        // FILT_N=1: late pulse every cycle, one add per period
        sync_rise(1);
        exp_q.push_back(31);
        exp_q.push_back(31);
        exp_q.push_back(31);
        exp_q.push_back(32);
        na = n_add[1];
        drive(1, 1'b0, 1'b1);
        for (int j = 0; j < 3; j++) begin
            wait_level(1, 1, 1'b1, 40, ok);
            chk("stream_add_seen", ok, 1);
        end
        drive(1, 1'b0, 1'b0);
        @(negedge clk32);
        drive(1, 1'b1, 1'b0);
        @(negedge clk32);
        drive(1, 1'b0, 1'b0);
        drain();
        chk("stream_add_count", n_add[1] - na, 3);

        // FILT_N=2: asynchronous reset at cnt=20 with filt=+1 while locked
        wait_level(2, 2, 1'b1, 400, ok);
        chk("u2_locked_pre", ok, 1);
        sync_rise(2);
        repeat (4) @(negedge clk32);
        drive(2, 1'b1, 1'b0);
        @(negedge clk32);
        drive(2, 1'b0, 1'b0);
        repeat (14) @(negedge clk32);
        chk("lock_before_rst", int'(if2.lock_o), 1);
        chk("clk_q_before_rst", int'(if2.clk_q_o), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_u2", int'(outs(2)), 0);
        repeat (2) @(negedge clk32);
        chk("rst_hold_u2", int'(outs(2)), 0);
        rst_n = 1'b1;
        repeat (4) exp_q.push_back(32);
        post_reset_checks(2);
        drain();
        nd = n_ded[2];
        drive(2, 1'b1, 1'b0);
        @(negedge clk32);
        drive(2, 1'b0, 1'b0);
        repeat (40) @(negedge clk32);
        chk("filt_cleared_by_rst", n_ded[2] - nd, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
